// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Program loader ahead of fetch. Packs opcode/register/funct/immediate fields
//   into RV32I R/I/S/B instruction words and writes them to consecutive words
//   of instruction memory over a write port with ack. Immediates that do not
//   fit their format are dropped, pulsed on err_pulse and counted.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   clear           sync abort: back to IDLE, load address 0, full dropped
//   in_valid/ready  request handshake (in_ready is combinational)
//   fmt             00=R 01=I 10=S 11=B
//   opcode, funct3, funct7, rd, rs1, rs2, imm   instruction fields
//   wr_en/addr/data memory write request, held until mem_ack
//   mem_ack         memory accepted the write this cycle
//   full            WORD_COUNT words written; no further requests accepted
//   err_pulse       one-cycle pulse per rejected request
//   err_count       saturating count of rejected requests (survives clear)
// -----------------------------------------------------------------------------
module instr_encoder #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 8,
   parameter int unsigned WORD_COUNT    = 64,
   parameter int unsigned ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               fmt,
   input  logic [6:0]               opcode,
   input  logic [2:0]               funct3,
   input  logic [6:0]               funct7,
   input  logic [4:0]               rd,
   input  logic [4:0]               rs1,
   input  logic [4:0]               rs2,
   input  logic [DATA_WIDTH-1:0]    imm,
   output logic                     wr_en,
   output logic [ADDR_WIDTH-1:0]    wr_addr,
   output logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     mem_ack,
   output logic                     full,
   output logic                     err_pulse,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   // word index must be able to hold WORD_COUNT itself (the full condition)
   localparam int unsigned IDX_W = $clog2(WORD_COUNT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ENC  = 2'd1,
      S_WR   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      FMT_R = 2'b00,
      FMT_I = 2'b01,
      FMT_S = 2'b10,
      FMT_B = 2'b11
   } fmt_e;

   state_e                   state_q;
   fmt_e                     fmt_q;
   logic [6:0]               opcode_q;
   logic [2:0]               funct3_q;
   logic [6:0]               funct7_q;
   logic [4:0]               rd_q;
   logic [4:0]               rs1_q;
   logic [4:0]               rs2_q;
   logic [DATA_WIDTH-1:0]    imm_q;

   logic [IDX_W-1:0]         word_idx_q;
   logic [IDX_W-1:0]         word_idx_d;
   logic                     wr_en_q;
   logic [ADDR_WIDTH-1:0]    wr_addr_q;
   logic [DATA_WIDTH-1:0]    wr_data_q;
   logic                     full_q;
   logic                     err_pulse_q;
   logic [ERR_CNT_WIDTH-1:0] err_count_q;

   logic [DATA_WIDTH-1:0]    enc_d;
   logic                     legal_d;
   logic                     imm12_ok;
   logic                     imm13_ok;

   assign in_ready  = (state_q == S_IDLE) && !full_q && !clear;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign full      = full_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

   assign word_idx_d = word_idx_q + 1'b1;

   // Sign-extension check: all bits above the field's sign bit equal the sign bit
   assign imm12_ok = (&imm_q[DATA_WIDTH-1:11]) || !(|imm_q[DATA_WIDTH-1:11]);
   assign imm13_ok = (&imm_q[DATA_WIDTH-1:12]) || !(|imm_q[DATA_WIDTH-1:12]);

   always_comb begin
      enc_d   = '0;
      legal_d = 1'b1;
      unique case (fmt_q)
         FMT_R: begin
            enc_d = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
         end
         FMT_I: begin
            enc_d   = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
            legal_d = imm12_ok;
         end
         FMT_S: begin
            enc_d   = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
            legal_d = imm12_ok;
         end
         FMT_B: begin
            enc_d   = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                       imm_q[4:1], imm_q[11], opcode_q};
            legal_d = imm13_ok && !imm_q[0];
         end
         default: begin
            enc_d   = '0;
            legal_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         fmt_q       <= FMT_R;
         opcode_q    <= '0;
         funct3_q    <= '0;
         funct7_q    <= '0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         imm_q       <= '0;
         word_idx_q  <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         full_q      <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else if (clear) begin
         // clear beats a coincident mem_ack: the pending word is not counted
         state_q     <= S_IDLE;
         word_idx_q  <= '0;
         wr_en_q     <= 1'b0;
         full_q      <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         err_pulse_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (in_valid && !full_q) begin
                  fmt_q    <= fmt_e'(fmt);
                  opcode_q <= opcode;
                  funct3_q <= funct3;
                  funct7_q <= funct7;
                  rd_q     <= rd;
                  rs1_q    <= rs1;
                  rs2_q    <= rs2;
                  imm_q    <= imm;
                  state_q  <= S_ENC;
               end
            end
            S_ENC: begin
               if (legal_d) begin
                  wr_data_q <= enc_d;
                  wr_addr_q <= ADDR_WIDTH'({word_idx_q, 2'b00});
                  wr_en_q   <= 1'b1;
                  state_q   <= S_WR;
               end else begin
                  err_pulse_q <= 1'b1;
                  if (err_count_q != '1) begin
                     err_count_q <= err_count_q + 1'b1;
                  end
                  state_q <= S_IDLE;
               end
            end
            S_WR: begin
               if (mem_ack) begin
                  wr_en_q    <= 1'b0;
                  word_idx_q <= word_idx_d;
                  full_q     <= (word_idx_d == IDX_W'(WORD_COUNT));
                  state_q    <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               wr_en_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

   logic        clk;
   logic        rst;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  fmt;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        mem_ack;
   logic        full;
   logic        err_pulse;
   logic [7:0]  err_count;

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         sb_q[$];
   int unsigned n_checks;
   int unsigned n_errors;
   int unsigned exp_idx;
   int unsigned exp_err;

   instr_encoder #(
      .DATA_WIDTH   (32),
      .ADDR_WIDTH   (8),
      .WORD_COUNT   (4),
      .ERR_CNT_WIDTH(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .fmt      (fmt),
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7   (funct7),
      .rd       (rd),
      .rs1      (rs1),
      .rs2      (rs2),
      .imm      (imm),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .mem_ack  (mem_ack),
      .full     (full),
      .err_pulse(err_pulse),
      .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_fields(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [31:0] im);
      fmt    = f;
      opcode = op;
      funct3 = f3;
      funct7 = f7;
      rd     = d;
      rs1    = s1;
      rs2    = s2;
      imm    = im;
   endtask

   // One request through the full handshake; ack arrives ack_delay cycles after wr_en rises
   task automatic send(input string tag, input logic [1:0] f, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                       input bit legal, input logic [31:0] exp_data, input int unsigned ack_delay);
      wr_t e;
      wr_t got;
      check({tag, "_in_ready"}, 64'(in_ready), 64'(1'b1));
      drive_fields(f, op, f3, f7, d, s1, s2, im);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_wr_en_n1"}, 64'(wr_en), 64'(1'b0));
      if (legal) begin
         e.addr = 8'(exp_idx * 4);
         e.data = exp_data;
         sb_q.push_back(e);
      end
      tick();
      if (legal) begin
         check({tag, "_wr_en_n2"}, 64'(wr_en), 64'(1'b1));
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
         end else begin
            got = sb_q.pop_front();
            check({tag, "_addr"}, 64'(wr_addr), 64'(got.addr));
            check({tag, "_data"}, 64'(wr_data), 64'(got.data));
            for (int i = 0; i < int'(ack_delay); i++) begin
               tick();
               check({tag, "_hold_en"}, 64'(wr_en), 64'(1'b1));
               check({tag, "_hold_addr"}, 64'(wr_addr), 64'(got.addr));
               check({tag, "_hold_data"}, 64'(wr_data), 64'(got.data));
               check({tag, "_hold_rdy"}, 64'(in_ready), 64'(1'b0));
            end
         end
         mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
         check({tag, "_wr_en_drop"}, 64'(wr_en), 64'(1'b0));
         exp_idx++;
      end else begin
         exp_err++;
         check({tag, "_err_pulse"}, 64'(err_pulse), 64'(1'b1));
         check({tag, "_no_wr"}, 64'(wr_en), 64'(1'b0));
         check({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
         tick();
         check({tag, "_pulse_end"}, 64'(err_pulse), 64'(1'b0));
         check({tag, "_no_wr2"}, 64'(wr_en), 64'(1'b0));
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_idx  = 0;
      exp_err  = 0;
      rst      = 1'b1;
      clear    = 1'b0;
      in_valid = 1'b0;
      mem_ack  = 1'b0;
      drive_fields(2'b00, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
      tick();
      tick();

      // reset state
      check("rst_wr_en", 64'(wr_en), 64'(1'b0));
      check("rst_wr_addr", 64'(wr_addr), 64'(8'h00));
      check("rst_wr_data", 64'(wr_data), 64'(32'h0));
      check("rst_full", 64'(full), 64'(1'b0));
      check("rst_err_pulse", 64'(err_pulse), 64'(1'b0));
      check("rst_err_count", 64'(err_count), 64'(8'h00));
      rst = 1'b0;
      tick();
      check("rst_in_ready", 64'(in_ready), 64'(1'b1));

      // addi x1,x0,5 ; sw x2,8(x1) ; bne x1,x0,-4 with ack held off 3 cycles
      send("addi", 2'b01, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093, 0);
      send("sw", 2'b10, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020_A423, 0);
      send("bne", 2'b11, 7'h63, 3'd1, 7'h00, 5'd0, 5'd1, 5'd0, 32'hFFFF_FFFC, 1'b1,
           32'hFE00_9EE3, 3);

      // out-of-range immediates: odd branch offset, I immediate just past +2047
      send("b_odd", 2'b11, 7'h63, 3'd1, 7'h00, 5'd0, 5'd1, 5'd0, 32'd3, 1'b0, 32'h0, 0);
      send("i_2048", 2'b01, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0, 0);
      check("err_count_2", 64'(err_count), 64'(8'd2));

      // fourth word fills the memory
      send("addi_m1", 2'b01, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1,
           32'hFFF0_0093, 0);
      check("full_set", 64'(full), 64'(1'b1));
      check("full_not_ready", 64'(in_ready), 64'(1'b0));

      // request while full is ignored
      drive_fields(2'b01, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd7);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("full_ignore_wr_en", 64'(wr_en), 64'(1'b0));
         check("full_ignore_rdy", 64'(in_ready), 64'(1'b0));
      end
      in_valid = 1'b0;
      check("full_held", 64'(full), 64'(1'b1));

      // clear drops full, rewinds address, keeps err_count
      clear = 1'b1;
      #1;
      check("clear_rdy_low", 64'(in_ready), 64'(1'b0));
      tick();
      clear = 1'b0;
      #1;
      exp_idx = 0;
      check("clear_full", 64'(full), 64'(1'b0));
      check("clear_rdy", 64'(in_ready), 64'(1'b1));
      check("clear_err_kept", 64'(err_count), 64'(8'd2));
      send("add_r", 2'b00, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h0020_81B3, 0);

      // reset during WR: wr_en falls without waiting for a clock edge
      drive_fields(2'b01, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("pre_rst_wr_en", 64'(wr_en), 64'(1'b1));
      check("pre_rst_addr", 64'(wr_addr), 64'(8'h04));
      rst = 1'b1;
      #1;
      check("async_rst_wr_en", 64'(wr_en), 64'(1'b0));
      check("async_rst_addr", 64'(wr_addr), 64'(8'h00));
      check("async_rst_errcnt", 64'(err_count), 64'(8'h00));
      sb_q.delete();
      tick();
      rst = 1'b0;
      exp_idx = 0;
      exp_err = 0;
      tick();
      send("addi_post_rst", 2'b01, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1,
           32'h0050_0093, 1);

      // negative extreme of B range is legal, positive extreme of I range is legal
      send("b_min", 2'b11, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_F000, 1'b1,
           32'h8000_0063, 0);
      send("i_max", 2'b01, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd2047, 1'b1,
           32'h7FF0_0013, 0);
      check("sb_drained", 64'(sb_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
